// File: rtl/uart_core_param.sv
// Full-duplex UART core: shared 16x baud tick, TX and RX engines with optional parity,
// 1/2 stop bits, framing/parity flags, break handling and internal loopback.
module uart_core_param #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_WIDTH-1:0] baud_div,
  input  logic                 loopback,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic       PAR_EN    = (PARITY != 0);
  localparam logic       PAR_ODD   = (PARITY == 1);

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;

  tx_state_t tx_state, tx_state_n;
  rx_state_t rx_state, rx_state_n;

  logic [DIV_WIDTH-1:0] div_q, tick_cnt;
  logic                 tick;

  // The divisor is only sampled while both engines are idle so a frame never changes speed.
  assign tick = (tick_cnt >= div_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      tick_cnt <= '0;
    end else begin
      if (tx_state == TX_IDLE && rx_state == RX_IDLE)
        div_q <= baud_div;
      tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
    end
  end

  logic [DATA_BITS-1:0] tx_shift, tx_shift_n;
  logic [3:0]           tx_sub, tx_sub_n, tx_bit, tx_bit_n;
  logic                 tx_par, tx_par_n, tx_line, tx_line_n;
  logic                 tx_bit_end;

  assign tx_bit_end = tick && (tx_sub == 4'hF);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state <= TX_IDLE;
      tx_shift <= '0;
      tx_sub   <= '0;
      tx_bit   <= '0;
      tx_par   <= 1'b0;
      tx_line  <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_shift <= tx_shift_n;
      tx_sub   <= tx_sub_n;
      tx_bit   <= tx_bit_n;
      tx_par   <= tx_par_n;
      tx_line  <= tx_line_n;
    end
  end

  // The 4-bit sub-tick counter wraps by itself, so each bit lasts exactly 16 ticks.
  always_comb begin
    tx_state_n = tx_state;
    tx_shift_n = tx_shift;
    tx_sub_n   = tx_sub;
    tx_bit_n   = tx_bit;
    tx_par_n   = tx_par;
    tx_line_n  = tx_line;
    if (tx_state != TX_IDLE && tick)
      tx_sub_n = tx_sub + 4'd1;
    case (tx_state)
      TX_IDLE: begin
        tx_line_n = 1'b1;
        if (tx_valid) begin
          tx_shift_n = tx_data;
          tx_par_n   = (^tx_data) ^ PAR_ODD;
          tx_sub_n   = '0;
          tx_bit_n   = '0;
          tx_line_n  = 1'b0;
          tx_state_n = TX_START;
        end
      end
      TX_START: begin
        if (tx_bit_end) begin
          tx_line_n  = tx_shift[0];
          tx_state_n = TX_DATA;
        end
      end
      TX_DATA: begin
        if (tx_bit_end) begin
          tx_shift_n = tx_shift >> 1;
          if (tx_bit == LAST_DATA) begin
            tx_bit_n   = '0;
            tx_line_n  = PAR_EN ? tx_par : 1'b1;
            tx_state_n = PAR_EN ? TX_PARITY : TX_STOP;
          end else begin
            tx_bit_n  = tx_bit + 4'd1;
            tx_line_n = tx_shift[1];
          end
        end
      end
      TX_PARITY: begin
        if (tx_bit_end) begin
          tx_line_n  = 1'b1;
          tx_state_n = TX_STOP;
        end
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_bit == LAST_STOP) begin
            tx_bit_n   = '0;
            tx_state_n = TX_IDLE;
          end else begin
            tx_bit_n = tx_bit + 4'd1;
          end
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
  end

  assign tx_ready = (tx_state == TX_IDLE);
  assign tx_busy  = !tx_ready;
  assign tx       = loopback ? 1'b1 : tx_line;

  logic                 rx_meta, rx_sync, rx_line, rx_sample;
  logic [DATA_BITS-1:0] rx_shift, rx_shift_n, rx_data_n;
  logic [3:0]           rx_sub, rx_sub_n, rx_bit, rx_bit_n;
  logic                 rx_par, rx_par_n, rx_perr, rx_perr_n;
  logic                 rx_valid_n, rx_parity_err_n, rx_frame_err_n;

  assign rx_line   = loopback ? tx_line : rx_sync;
  assign rx_sample = tick && (rx_sub == ((rx_state == RX_START) ? 4'd7 : 4'd15));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta       <= 1'b1;
      rx_sync       <= 1'b1;
      rx_state      <= RX_IDLE;
      rx_shift      <= '0;
      rx_sub        <= '0;
      rx_bit        <= '0;
      rx_par        <= 1'b0;
      rx_perr       <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_meta       <= rx;
      rx_sync       <= rx_meta;
      rx_state      <= rx_state_n;
      rx_shift      <= rx_shift_n;
      rx_sub        <= rx_sub_n;
      rx_bit        <= rx_bit_n;
      rx_par        <= rx_par_n;
      rx_perr       <= rx_perr_n;
      rx_data       <= rx_data_n;
      rx_valid      <= rx_valid_n;
      rx_parity_err <= rx_parity_err_n;
      rx_frame_err  <= rx_frame_err_n;
    end
  end

  // A zero stop bit parks RX in BREAK until the line returns high, so a held-low line yields one pulse.
  always_comb begin
    rx_state_n      = rx_state;
    rx_shift_n      = rx_shift;
    rx_sub_n        = rx_sub;
    rx_bit_n        = rx_bit;
    rx_par_n        = rx_par;
    rx_perr_n       = rx_perr;
    rx_data_n       = rx_data;
    rx_valid_n      = 1'b0;
    rx_parity_err_n = rx_parity_err;
    rx_frame_err_n  = rx_frame_err;
    if (tick && rx_state != RX_IDLE && rx_state != RX_BREAK)
      rx_sub_n = rx_sub + 4'd1;
    case (rx_state)
      RX_IDLE: begin
        if (!rx_line) begin
          rx_sub_n   = '0;
          rx_bit_n   = '0;
          rx_par_n   = 1'b0;
          rx_perr_n  = 1'b0;
          rx_state_n = RX_START;
        end
      end
      RX_START: begin
        if (rx_sample) begin
          rx_sub_n   = '0;
          rx_state_n = rx_line ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_sample) begin
          rx_shift_n = {rx_line, rx_shift[DATA_BITS-1:1]};
          rx_par_n   = rx_par ^ rx_line;
          if (rx_bit == LAST_DATA) begin
            rx_bit_n   = '0;
            rx_state_n = PAR_EN ? RX_PARITY : RX_STOP;
          end else begin
            rx_bit_n = rx_bit + 4'd1;
          end
        end
      end
      RX_PARITY: begin
        if (rx_sample) begin
          rx_perr_n  = rx_par ^ rx_line ^ PAR_ODD;
          rx_state_n = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_sample) begin
          rx_valid_n      = 1'b1;
          rx_data_n       = rx_shift;
          rx_parity_err_n = rx_perr;
          rx_frame_err_n  = !rx_line;
          rx_state_n      = rx_line ? RX_IDLE : RX_BREAK;
        end
      end
      RX_BREAK: begin
        if (rx_line)
          rx_state_n = RX_IDLE;
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_core_param.sv
// Directed bench for uart_core_param: an 8N1 instance (A) and an 8E2 instance (B) sharing clock and reset.
module tb_uart_core_param;

  logic        clk;
  logic        rst;
  int          checkCount = 0;
  int          errorCount = 0;
  int          aPulses = 0;
  int          bPulses = 0;

  logic [15:0] aBaudDiv, bBaudDiv;
  logic        aLoopback, bLoopback, aTxValid, bTxValid, aRx, bRx;
  logic [7:0]  aTxData, bTxData, aRxData, bRxData;
  logic        aTxReady, bTxReady, aTx, bTx, aTxBusy, bTxBusy;
  logic        aRxValid, bRxValid, aRxPerr, bRxPerr, aRxFerr, bRxFerr;

  uart_core_param dutA (
    .clk(clk), .rst(rst), .baud_div(aBaudDiv), .loopback(aLoopback),
    .tx_valid(aTxValid), .tx_data(aTxData), .tx_ready(aTxReady), .tx(aTx), .tx_busy(aTxBusy),
    .rx(aRx), .rx_data(aRxData), .rx_valid(aRxValid), .rx_parity_err(aRxPerr), .rx_frame_err(aRxFerr)
  );

  uart_core_param #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .DIV_WIDTH(16)) dutB (
    .clk(clk), .rst(rst), .baud_div(bBaudDiv), .loopback(bLoopback),
    .tx_valid(bTxValid), .tx_data(bTxData), .tx_ready(bTxReady), .tx(bTx), .tx_busy(bTxBusy),
    .rx(bRx), .rx_data(bRxData), .rx_valid(bRxValid), .rx_parity_err(bRxPerr), .rx_frame_err(bRxFerr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (aRxValid) aPulses = aPulses + 1;
    if (bRxValid) bPulses = bPulses + 1;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=expired expected=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives nbits of a serial frame (LSB first) onto the selected rx pin, bitClocks per bit.
  task automatic applyStimulus(input int which, input logic [15:0] bits, input int nbits, input int bitClocks);
    for (int b = 0; b < nbits; b++) begin
      if (which == 0) aRx = bits[b];
      else bRx = bits[b];
      repeat (bitClocks) @(negedge clk);
    end
  endtask

  task automatic sendByte(input int which, input logic [7:0] data, input logic hold);
    @(negedge clk);
    checkOutput("tx_ready before send", 32'((which == 0) ? aTxReady : bTxReady), 32'h1);
    if (which == 0) begin aTxValid = 1'b1; aTxData = data; end
    else begin bTxValid = 1'b1; bTxData = data; end
    @(posedge clk);
    if (!hold) begin
      #1;
      if (which == 0) aTxValid = 1'b0;
      else bTxValid = 1'b0;
    end
  endtask

  // Starts right after an accepting edge: counts tx_ready-low cycles and samples tx mid-bit.
  task automatic captureFrame(input int which, input int bitClocks, input int nbits,
                              output logic [15:0] bits, output int lowCycles);
    logic done;
    logic rdy;
    bits = '0;
    lowCycles = 0;
    done = 1'b0;
    for (int i = 1; i <= 4000 && !done; i++) begin
      @(negedge clk);
      rdy = (which == 0) ? aTxReady : bTxReady;
      if (rdy) done = 1'b1;
      else begin
        lowCycles++;
        for (int b = 0; b < nbits; b++)
          if (i == bitClocks / 2 + b * bitClocks) bits[b] = (which == 0) ? aTx : bTx;
      end
    end
  endtask

  logic [15:0] bits;
  int          low, p0;

  initial begin
    rst = 1'b0;
    aBaudDiv = '0; bBaudDiv = '0; aLoopback = 1'b0; bLoopback = 1'b0;
    aTxValid = 1'b0; bTxValid = 1'b0; aTxData = '0; bTxData = '0; aRx = 1'b1; bRx = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset tx", 32'(aTx), 32'h1);
    checkOutput("reset tx_busy", 32'(aTxBusy), 32'h0);
    checkOutput("reset rx_valid", 32'(aRxValid), 32'h0);
    checkOutput("reset rx_data", 32'(aRxData), 32'h0);
    checkOutput("reset perr", 32'(bRxPerr), 32'h0);
    checkOutput("reset ferr", 32'(aRxFerr), 32'h0);
    checkOutput("reset b tx", 32'(bTx), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("release tx_ready", 32'(aTxReady), 32'h1);
    checkOutput("release b tx_ready", 32'(bTxReady), 32'h1);

    // 8N1 loopback, one clock per tick
    aLoopback = 1'b1;
    repeat (4) @(negedge clk);
    p0 = aPulses;
    sendByte(0, 8'hA5, 1'b0);
    captureFrame(0, 16, 10, bits, low);
    checkOutput("t1 ready low cycles", 32'(low), 32'd160);
    checkOutput("t1 tx pin held high", 32'(bits), 32'h3FF);
    repeat (20) @(negedge clk);
    checkOutput("t1 pulses", 32'(aPulses - p0), 32'd1);
    checkOutput("t1 rx_data", 32'(aRxData), 32'hA5);
    checkOutput("t1 perr", 32'(aRxPerr), 32'h0);
    checkOutput("t1 ferr", 32'(aRxFerr), 32'h0);
    aLoopback = 1'b0;
    repeat (4) @(negedge clk);

    // Even parity: wrong parity bit, then a correct one
    p0 = bPulses;
    applyStimulus(1, 16'hE78, 12, 16);
    repeat (20) @(negedge clk);
    checkOutput("t2 pulses", 32'(bPulses - p0), 32'd1);
    checkOutput("t2 rx_data", 32'(bRxData), 32'h3C);
    checkOutput("t2 perr", 32'(bRxPerr), 32'h1);
    checkOutput("t2 ferr", 32'(bRxFerr), 32'h0);
    applyStimulus(1, 16'hE0E, 12, 16);
    repeat (20) @(negedge clk);
    checkOutput("t2 good rx_data", 32'(bRxData), 32'h07);
    checkOutput("t2 good perr", 32'(bRxPerr), 32'h0);

    // Framing error, then a long break
    p0 = aPulses;
    applyStimulus(0, 16'h0AA, 10, 16);
    aRx = 1'b1;
    repeat (48) @(negedge clk);
    checkOutput("t3 pulses", 32'(aPulses - p0), 32'd1);
    checkOutput("t3 rx_data", 32'(aRxData), 32'h55);
    checkOutput("t3 ferr", 32'(aRxFerr), 32'h1);
    p0 = aPulses;
    aRx = 1'b0;
    repeat (480) @(negedge clk);
    aRx = 1'b1;
    repeat (64) @(negedge clk);
    checkOutput("t3 break pulses", 32'(aPulses - p0), 32'd1);
    checkOutput("t3 break rx_data", 32'(aRxData), 32'h00);
    checkOutput("t3 break ferr", 32'(aRxFerr), 32'h1);

    // Glitch shorter than half a bit, then a clean 0x81
    p0 = aPulses;
    aRx = 1'b0;
    repeat (4) @(negedge clk);
    aRx = 1'b1;
    repeat (64) @(negedge clk);
    checkOutput("t4 false start pulses", 32'(aPulses - p0), 32'd0);
    applyStimulus(0, 16'h302, 10, 16);
    repeat (32) @(negedge clk);
    checkOutput("t4 pulses", 32'(aPulses - p0), 32'd1);
    checkOutput("t4 rx_data", 32'(aRxData), 32'h81);
    checkOutput("t4 ferr", 32'(aRxFerr), 32'h0);

    // Held tx_valid, 2 stop bits, divisor change deferred to the next frame
    bBaudDiv = 16'd3;
    repeat (10) @(negedge clk);
    sendByte(1, 8'h11, 1'b1);
    fork
      captureFrame(1, 64, 12, bits, low);
      begin
        @(negedge clk);
        bTxData = 8'h22;
        repeat (100) @(negedge clk);
        bBaudDiv = 16'd1;
      end
    join
    checkOutput("t5 frame1 bits", 32'(bits), 32'hC22);
    checkOutput("t5 frame1 length ok", 32'(low >= 765 && low <= 768), 32'h1);
    fork
      captureFrame(1, 32, 12, bits, low);
      begin
        @(negedge clk);
        bTxValid = 1'b0;
      end
    join
    checkOutput("t5 frame2 bits", 32'(bits), 32'hC44);
    checkOutput("t5 frame2 length ok", 32'(low >= 383 && low <= 384), 32'h1);

    // Reset in the middle of a TX and an RX frame
    p0 = aPulses;
    fork
      sendByte(0, 8'h3C, 1'b0);
      applyStimulus(0, 16'h302, 4, 16);
    join
    rst = 1'b0;
    @(negedge clk);
    checkOutput("t6 tx in reset", 32'(aTx), 32'h1);
    checkOutput("t6 busy in reset", 32'(aTxBusy), 32'h0);
    aRx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("t6 pulses", 32'(aPulses - p0), 32'd0);
    checkOutput("t6 rx_data cleared", 32'(aRxData), 32'h00);
    checkOutput("t6 tx_ready", 32'(aTxReady), 32'h1);
    sendByte(0, 8'h96, 1'b0);
    captureFrame(0, 16, 10, bits, low);
    checkOutput("t6 frame bits", 32'(bits), 32'h32C);
    checkOutput("t6 ready low cycles", 32'(low), 32'd160);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
